// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder producing a WIDTH-bit sum LSB-first over
// WIDTH cycles through a single full-adder cell and a registered carry.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   start    - request an addition (sampled only while idle)
//   a, b, ci - operands and carry-in, captured on the accepting edge
//   busy     - high while bits are being processed
//   done     - one-cycle pulse when s/co carry a fresh result
//   s, co    - registered sum and carry-out, held until the next completion

module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADD  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    // Partial sum keeps only WIDTH-1 bits: the final bit is merged in
    // directly when the result is committed to s.
    logic [WIDTH-2:0]   s_sr_r;
    logic               c_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   s_r;
    logic               co_r;
    logic               busy_r;
    logic               done_r;
    logic               fa_s_s;
    logic               fa_co_s;
    logic [WIDTH-1:0]   s_cat_s;
    logic               last_bit_s;

    fa u_fa (
        .a  (a_sr_r[0]),
        .b  (b_sr_r[0]),
        .ci (c_r),
        .s  (fa_s_s),
        .co (fa_co_s)
    );

    // Sum register with the current sum bit entering at the MSB end.
    assign s_cat_s    = {fa_s_s, s_sr_r};
    assign last_bit_s = (cnt_r == LAST_BIT);

    // Next-state logic for the IDLE -> ADD -> DONE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ADD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (last_bit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ADD;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done flags decoded from next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_ADD);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand shift registers, carry, bit counter and committed result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sr_r <= {WIDTH{1'b0}};
            b_sr_r <= {WIDTH{1'b0}};
            s_sr_r <= {(WIDTH-1){1'b0}};
            c_r    <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            s_r    <= {WIDTH{1'b0}};
            co_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_sr_r <= a;
                        b_sr_r <= b;
                        c_r    <= ci;
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                ST_ADD: begin
                    a_sr_r <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r <= {1'b0, b_sr_r[WIDTH-1:1]};
                    s_sr_r <= s_cat_s[WIDTH-1:1];
                    c_r    <= fa_co_s;
                    if (last_bit_s) begin
                        // Counter parks at zero instead of wrapping.
                        cnt_r <= {CNT_W{1'b0}};
                        s_r   <= s_cat_s;
                        co_r  <= fa_co_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign co   = co_r;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that computes a WIDTH-bit sum LSB-first over WIDTH clock cycles. It uses a single `fa` full-adder cell and a registered carry. It is the sequential stage that drives `fa`: it loads two operands, shifts one bit pair per cycle through the cell, and collects the sum bits. It is the low-area alternative to the ripple-carry adder for multi-cycle datapaths.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Legal range is 2 to 32.
- `clk`  in  1: clock. All state changes occur on the rising edge.
- `reset_n`  in  1: reset. Asynchronous and active-low.
- `start`  in  1: request to start an addition. Sampled only in IDLE.
- `a`  in  WIDTH: operand A. Captured on the accepting edge.
- `b`  in  WIDTH: operand B. Captured on the accepting edge.
- `ci`  in  1: carry-in. Captured on the accepting edge.
- `busy`  out  1: high while in ADD.
- `done`  out  1: one-cycle pulse in DONE. `s` and `co` are valid from this cycle onward.
- `s`  out  WIDTH: registered sum. Holds the last result until the next completion.
- `co`  out  1: registered carry-out of the MSB. Holds like `s`.

## Operation
- State machine has three states: IDLE, ADD, DONE. Encoding is free.
- IDLE, with `start`=1 on a clock edge:
  - load shift registers A_sr←`a` and B_sr←`b`;
  - carry register c←`ci`;
  - bit counter←0;
  - go to ADD.
- IDLE, with `start`=0: stay in IDLE.
- ADD, on each edge:
  - the `fa` instance takes inputs A_sr[0], B_sr[0], c;
  - sum bit is shifted into S_sr at the MSB end (S_sr ← {sum, S_sr[WIDTH-1:1]});
  - A_sr and B_sr shift right by one;
  - c←fa carry-out;
  - counter increments.
- ADD, on the edge that processes bit WIDTH-1:
  - `s`←final S_sr value, including this bit;
  - `co`←fa carry-out;
  - go to DONE.
- DONE: `done`=1 for exactly one cycle, then unconditionally go to IDLE.
- `start` is ignored in ADD and DONE. It is not queued.
- Operand inputs are don't-care outside the accepting edge. Changing them mid-operation must not affect the result.
- Arithmetic: {`co`,`s`} = `a` + `b` + `ci`, exact and unsigned, modulo 2^(WIDTH+1).
- Counter width is clog2(WIDTH). Counter compare uses WIDTH-1. There is no wrap-around.
- `s` and `co` are updated only on entry to DONE. They stay stable during ADD and hold the previous result.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - state←IDLE;
  - `busy`=0, `done`=0, `s`=0, `co`=0;
  - shift registers, carry and counter cleared.
- Reset asserted mid-ADD aborts the operation. No `done` is produced and `s`/`co` read 0.
- Release of reset is synchronous in effect: the first `start` is honoured on the first rising edge with `reset_n`=1.
- Let edge E0 be the edge that accepts `start`. Then:
  - `busy`=1 from just after E0 until edge E_WIDTH;
  - bits 0..WIDTH-1 are processed on edges E1..E_WIDTH;
  - `done`=1 and `s`/`co` are valid in the cycle after E_WIDTH;
  - latency from the accepting edge to `done` is WIDTH cycles.
- State returns to IDLE at E_WIDTH+1. The earliest next accepting edge is E_WIDTH+2, so throughput is one add per WIDTH+2 cycles.
- `busy` and `done` are never high together.
- Outputs are driven directly from registers. There is no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=8.
- **Reset values.** Assert `reset_n`=0 at an arbitrary time. Expect `busy`=0, `done`=0, `s`=8'h00, `co`=0 immediately, without waiting for a clock edge.
- **Basic adds.**
  - `a`=8'h3C, `b`=8'h42, `ci`=0: `done` pulses exactly 8 cycles after the accepting edge, with `s`=8'h7E and `co`=0.
  - `a`=8'h00, `b`=8'h00, `ci`=0: `s`=8'h00, `co`=0.
- **Full carry ripple.**
  - `a`=8'hFF, `b`=8'h01, `ci`=0: `s`=8'h00, `co`=1.
  - `a`=8'hA5, `b`=8'h5A, `ci`=1: `s`=8'h00, `co`=1.
  - `a`=8'hFF, `b`=8'hFF, `ci`=1: `s`=8'hFF, `co`=1.
- **Input isolation and start-while-busy.** Start 8'h12+8'h34, then hold `start`=1 and change `a`/`b` every cycle during ADD. Expect one `done` with `s`=8'h46 and `co`=0. A second operation begins only from IDLE.
- **Reset mid-operation.** Pulse `reset_n` low after bit 4 is processed. Expect `busy` to drop immediately, no `done`, and `s`=0. A following start with 8'h01+8'h01 yields `s`=8'h02.
- **Back-to-back.** Hold `start`=1 continuously with fixed operands 8'h80+8'h80. Expect `done` every 10 cycles, each time with `s`=8'h00 and `co`=1, and `s` stable between pulses.
